reg_access_ctrl: RTL and testbench

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/reg_pkg.sv | 15 +
 rtl/reg_scoreboard.sv | 41 ++++
 rtl/reg_access_ctrl.sv | 120 ++++++++++++
 tb/tb_reg_access_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the register access controller: default widths,
// register count and the issue FSM state encoding.
package reg_pkg;

   localparam int DATA_W   = 9;
   localparam int ADDR_W   = 2;
   localparam int NUM_REGS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register marks an outstanding
// writeback. Hazard compare uses only the registered mask, so a writeback
// releases dependants one cycle after it arrives.
module reg_scoreboard #(
   parameter int ADDR_W   = reg_pkg::ADDR_W,
   parameter int NUM_REGS = reg_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] src0,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] dst,
   input  logic              dst_wb,
   input  logic              set_en,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   output logic              hazard
);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_nxt;

   // Hazard when a source is pending, or the destination is pending for a writing op
   always_comb begin
      hazard = pending[src0] | pending[src1] | (dst_wb & pending[dst]);
   end

   // Next mask: clear first, then set, so a same-edge set of one bit wins
   always_comb begin
      pending_nxt = pending;
      if (clr_en) pending_nxt[clr_addr] = 1'b0;
      if (set_en) pending_nxt[dst]      = 1'b1;
   end

   // Mask register
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pending_nxt;
   end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register access controller: accepts one issue at a time, reads both source
// operands from the register file (with bypass from a same-edge writeback),
// and presents them as a held operand bundle until the ALU takes it.
module reg_access_ctrl import reg_pkg::*; #(
   parameter int DATA_W = reg_pkg::DATA_W,
   parameter int ADDR_W = reg_pkg::ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     iss_valid,
   output logic                     iss_ready,
   input  logic [ADDR_W-1:0]        iss_src0,
   input  logic [ADDR_W-1:0]        iss_src1,
   input  logic [ADDR_W-1:0]        iss_dst,
   input  logic                     iss_wb,
   output logic                     op_valid,
   input  logic                     op_ready,
   output logic signed [DATA_W-1:0] op_data0,
   output logic signed [DATA_W-1:0] op_data1,
   output logic [ADDR_W-1:0]        op_dst,
   input  logic                     wb_valid,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic signed [DATA_W-1:0] wb_data,
   output logic                     rf_rd_en,
   output logic [ADDR_W-1:0]        rf_rd0_addr,
   output logic [ADDR_W-1:0]        rf_rd1_addr,
   output logic                     rf_wr_en,
   output logic [ADDR_W-1:0]        rf_wr_addr,
   output logic signed [DATA_W-1:0] rf_wr_data,
   input  logic signed [DATA_W-1:0] rf_rd0_data,
   input  logic signed [DATA_W-1:0] rf_rd1_data
);

   state_e state_q, state_d;
   logic   hazard;
   logic   accept;
   logic   op_accept;

   logic                     byp0_p0;
   logic                     byp1_p0;
   logic signed [DATA_W-1:0] byp_data_p0;
   logic [ADDR_W-1:0]        dst_p0;

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (1 << ADDR_W)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .src0     (iss_src0),
      .src1     (iss_src1),
      .dst      (iss_dst),
      .dst_wb   (iss_wb),
      .set_en   (accept & iss_wb),
      .clr_en   (wb_valid),
      .clr_addr (wb_addr),
      .hazard   (hazard)
   );

   // Handshakes and register-file port drive; reset masks both RF strobes
   always_comb begin
      iss_ready   = (state_q == ST_IDLE) && !hazard;
      accept      = iss_valid && iss_ready && !rst;
      op_accept   = op_valid && op_ready;
      rf_rd_en    = accept;
      rf_rd0_addr = iss_src0;
      rf_rd1_addr = iss_src1;
      rf_wr_en    = wb_valid && !rst;
      rf_wr_addr  = wb_addr;
      rf_wr_data  = wb_data;
   end

   // FSM next state: one read cycle, then hold until the bundle is taken
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = ST_READ;
         ST_READ:                state_d = ST_HOLD;
         ST_HOLD: if (op_accept) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Stage p0 (accept edge): note same-edge writeback hits on either source
   always_ff @(posedge clk) begin
      if (accept) begin
         byp0_p0     <= wb_valid && (wb_addr == iss_src0);
         byp1_p0     <= wb_valid && (wb_addr == iss_src1);
         byp_data_p0 <= wb_data;
         dst_p0      <= iss_dst;
      end
   end

   // Stage p1 (read edge): capture operands, bypass overriding stale RF data
   always_ff @(posedge clk) begin
      if (rst) begin
         op_data0 <= '0;
         op_data1 <= '0;
         op_dst   <= '0;
      end else if (state_q == ST_READ) begin
         op_data0 <= byp0_p0 ? byp_data_p0 : rf_rd0_data;
         op_data1 <= byp1_p0 ? byp_data_p0 : rf_rd1_data;
         op_dst   <= dst_p0;
      end
   end

   // Bundle valid: raised with the capture, dropped when the ALU accepts
   always_ff @(posedge clk) begin
      if (rst)                       op_valid <= 1'b0;
      else if (state_q == ST_READ)   op_valid <= 1'b1;
      else if (op_accept)            op_valid <= 1'b0;
   end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: directed sequences, a table of issue vectors
// with hand-computed operands, and a randomized run against an
// architectural model (register values, pending set, one outstanding bundle).
module tb_reg_access_ctrl;

   logic              clk = 1'b0;
   logic              rst;
   logic              iss_valid;
   logic              iss_ready;
   logic [1:0]        iss_src0, iss_src1, iss_dst;
   logic              iss_wb;
   logic              op_valid;
   logic              op_ready;
   logic signed [8:0] op_data0, op_data1;
   logic [1:0]        op_dst;
   logic              wb_valid;
   logic [1:0]        wb_addr;
   logic signed [8:0] wb_data;
   logic              rf_rd_en;
   logic [1:0]        rf_rd0_addr, rf_rd1_addr;
   logic              rf_wr_en;
   logic [1:0]        rf_wr_addr;
   logic signed [8:0] rf_wr_data;
   logic signed [8:0] rf_rd0_data, rf_rd1_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg_access_ctrl dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_src0(iss_src0), .iss_src1(iss_src1), .iss_dst(iss_dst), .iss_wb(iss_wb),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_data0(op_data0), .op_data1(op_data1), .op_dst(op_dst),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_rd_en(rf_rd_en), .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data)
   );

   // Register file environment: synchronous read (old data on same-edge write)
   logic signed [8:0] rf_env [4] = '{default: '0};
   always @(posedge clk) begin
      if (rf_rd_en) begin
         rf_rd0_data <= rf_env[rf_rd0_addr];
         rf_rd1_data <= rf_env[rf_rd1_addr];
      end
      if (rf_wr_en) rf_env[rf_wr_addr] <= rf_wr_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic write_reg(input logic [1:0] a, input int d);
      wb_valid = 1'b1; wb_addr = a; wb_data = d[8:0];
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic do_issue(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] d,
                           input logic wb, input logic wbv, input logic [1:0] wa, input int wd);
      iss_valid = 1'b1; iss_src0 = s0; iss_src1 = s1; iss_dst = d; iss_wb = wb;
      wb_valid = 1'b0;
      #1;
      for (int i = 0; i < 20 && !iss_ready; i++) tick();
      if (!iss_ready) begin
         check("issue_timeout", 0, 1);
         iss_valid = 1'b0;
         return;
      end
      wb_valid = wbv; wb_addr = wa; wb_data = wd[8:0];
      tick();
      iss_valid = 1'b0; wb_valid = 1'b0; iss_wb = 1'b0;
   endtask

   task automatic collect(output int d0, output int d1, output int dd);
      for (int i = 0; i < 10 && !op_valid; i++) tick();
      if (!op_valid) begin
         check("op_timeout", 0, 1);
         d0 = 0; d1 = 0; dd = 0;
         return;
      end
      d0 = op_data0; d1 = op_data1; dd = op_dst;
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
   endtask

   typedef struct {
      logic [1:0] s0, s1, dst;
      logic       wbv;
      logic [1:0] wa;
      int         wd;
      int         e0, e1;
   } vec_t;

   vec_t tbl [7];

   // Randomized-phase model state
   int arch [4];
   bit pend [4];
   bit outst;
   int age, q0, q1, qd;

   initial begin
      int d0, d1, dd;
      int s0v, s1v, dv, wav, wdv;
      bit ivv, wbb, wbvv, orv, acc, exp_ov, exp_rdy;
      bit p_iv, p_wb, p_wbv, p_or, p_rdy, p_ov;
      int p_s0, p_s1, p_d, p_wa, p_wd;

      // Register contents at table time: R0=11 R1=5 R2=-3 R3=7
      tbl[0] = '{2'd0, 2'd3, 2'd2, 1'b0, 2'd0,    0,   11,    7};
      tbl[1] = '{2'd2, 2'd2, 2'd1, 1'b1, 2'd2, -100, -100, -100};
      tbl[2] = '{2'd2, 2'd0, 2'd0, 1'b0, 2'd0,    0, -100,   11};
      tbl[3] = '{2'd3, 2'd1, 2'd3, 1'b1, 2'd1,  255,    7,  255};
      tbl[4] = '{2'd1, 2'd0, 2'd2, 1'b1, 2'd0, -256,  255, -256};
      tbl[5] = '{2'd3, 2'd3, 2'd1, 1'b1, 2'd2,   42,    7,    7};
      tbl[6] = '{2'd2, 2'd1, 2'd0, 1'b0, 2'd0,    0,   42,  255};

      rst = 1'b1; iss_valid = 1'b0; iss_src0 = '0; iss_src1 = '0; iss_dst = '0;
      iss_wb = 1'b0; op_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;

      // Reset: strobes masked even with requests present
      tick();
      iss_valid = 1'b1; wb_valid = 1'b1; wb_addr = 2'd1; wb_data = 9'sd77;
      #1;
      check("rst_rd_en", rf_rd_en, 0);
      check("rst_wr_en", rf_wr_en, 0);
      tick();
      check("rst_op_valid", op_valid, 0);
      check("rst_op_data0", op_data0, 0);
      check("rst_op_data1", op_data1, 0);
      check("rst_op_dst", op_dst, 0);
      iss_valid = 1'b0; wb_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("post_rst_ready", iss_ready, 1);

      write_reg(2'd0, 11);
      write_reg(2'd1, 5);
      write_reg(2'd2, -3);
      write_reg(2'd3, 100);

      // Basic issue with latency, then a 4-cycle stall in HOLD
      iss_valid = 1'b1; iss_src0 = 2'd1; iss_src1 = 2'd2; iss_dst = 2'd3; iss_wb = 1'b1;
      #1;
      check("issue_ready", iss_ready, 1);
      check("issue_rd_en", rf_rd_en, 1);
      check("issue_rd0_addr", rf_rd0_addr, 1);
      check("issue_rd1_addr", rf_rd1_addr, 2);
      tick();
      iss_valid = 1'b0; iss_wb = 1'b0;
      check("lat_n_op_valid", op_valid, 0);
      tick();
      check("lat_n1_op_valid", op_valid, 1);
      check("lat_op_data0", op_data0, 5);
      check("lat_op_data1", op_data1, -3);
      check("lat_op_dst", op_dst, 3);
      iss_valid = 1'b1; iss_src0 = 2'd0; iss_src1 = 2'd0; iss_dst = 2'd0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall_valid", op_valid, 1);
         check("stall_data0", op_data0, 5);
         check("stall_data1", op_data1, -3);
         check("stall_dst", op_dst, 3);
         check("stall_ready", iss_ready, 0);
      end
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0; iss_valid = 1'b0;
      check("after_hold_ready", iss_ready, 1);
      check("after_hold_valid", op_valid, 0);

      // R3 pending: dependant stalls until the cycle after its writeback
      iss_valid = 1'b1; iss_src0 = 2'd3; iss_src1 = 2'd0; iss_dst = 2'd0; iss_wb = 1'b0;
      #1;
      check("raw_ready0", iss_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("raw_ready_wait", iss_ready, 0);
      end
      wb_valid = 1'b1; wb_addr = 2'd3; wb_data = 9'sd7;
      #1;
      check("raw_ready_wb_cycle", iss_ready, 0);
      tick();
      wb_valid = 1'b0;
      check("raw_ready_after_wb", iss_ready, 1);
      tick();
      iss_valid = 1'b0;
      collect(d0, d1, dd);
      check("raw_op_data0", d0, 7);
      check("raw_op_data1", d1, 11);

      // Table of issues, including same-edge writeback bypass
      foreach (tbl[k]) begin
         do_issue(tbl[k].s0, tbl[k].s1, tbl[k].dst, 1'b0, tbl[k].wbv, tbl[k].wa, tbl[k].wd);
         collect(d0, d1, dd);
         check($sformatf("tbl%0d_data0", k), d0, tbl[k].e0);
         check($sformatf("tbl%0d_data1", k), d1, tbl[k].e1);
         check($sformatf("tbl%0d_dst", k), dd, tbl[k].dst);
      end

      // Set and clear of the same bit on one edge: set wins
      do_issue(2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 2'd1, 20);
      collect(d0, d1, dd);
      iss_src0 = 2'd1; iss_src1 = 2'd0;
      #1;
      check("setwins_pending", iss_ready, 0);
      write_reg(2'd1, 20);
      check("setwins_cleared", iss_ready, 1);

      // Reset while in READ discards the bundle and the pending bit
      do_issue(2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 2'd0, 0);
      rst = 1'b1; iss_valid = 1'b1; iss_src0 = 2'd0; iss_src1 = 2'd0;
      wb_valid = 1'b1; wb_addr = 2'd0; wb_data = 9'sd99;
      #1;
      check("midrst_rd_en", rf_rd_en, 0);
      check("midrst_wr_en", rf_wr_en, 0);
      tick();
      rst = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0;
      check("midrst_op_valid", op_valid, 0);
      check("midrst_op_data0", op_data0, 0);
      iss_src0 = 2'd2;
      #1;
      check("midrst_ready", iss_ready, 1);
      tick(); tick();
      check("midrst_no_bundle", op_valid, 0);

      // Randomized run against the architectural model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int r = 0; r < 4; r++) begin
         arch[r] = int'($urandom_range(0, 511)) - 256;
         pend[r] = 1'b0;
         write_reg(r[1:0], arch[r]);
      end
      outst = 1'b0; age = 0; q0 = 0; q1 = 0; qd = 0;
      p_iv = 0; p_wb = 0; p_wbv = 0; p_or = 0; p_rdy = 0; p_ov = 0;
      p_s0 = 0; p_s1 = 0; p_d = 0; p_wa = 0; p_wd = 0;
      iss_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b0;

      for (int cyc = 0; cyc < 800; cyc++) begin
         tick();
         acc = p_iv && p_rdy;
         if (p_ov && p_or) outst = 1'b0;
         if (p_wbv) begin
            arch[p_wa] = p_wd;
            pend[p_wa] = 1'b0;
         end
         if (acc) begin
            outst = 1'b1; age = 0;
            q0 = arch[p_s0]; q1 = arch[p_s1]; qd = p_d;
            if (p_wb) pend[p_d] = 1'b1;
         end else if (outst) begin
            age++;
         end
         exp_ov = outst && (age >= 1);
         check("rnd_op_valid", op_valid, int'(exp_ov));
         if (exp_ov && op_valid) begin
            check("rnd_op_data0", op_data0, q0);
            check("rnd_op_data1", op_data1, q1);
            check("rnd_op_dst", op_dst, qd);
         end

         ivv  = ($urandom_range(0, 9) < 6);
         s0v  = $urandom_range(0, 3);
         s1v  = $urandom_range(0, 3);
         dv   = $urandom_range(0, 3);
         wbb  = $urandom_range(0, 1);
         wbvv = ($urandom_range(0, 9) < 3);
         wav  = $urandom_range(0, 3);
         wdv  = int'($urandom_range(0, 511)) - 256;
         orv  = $urandom_range(0, 1);
         iss_valid = ivv; iss_src0 = s0v[1:0]; iss_src1 = s1v[1:0]; iss_dst = dv[1:0];
         iss_wb = wbb; wb_valid = wbvv; wb_addr = wav[1:0]; wb_data = wdv[8:0];
         op_ready = orv;
         #1;
         exp_rdy = !outst && !pend[s0v] && !pend[s1v] && !(wbb && pend[dv]);
         check("rnd_iss_ready", iss_ready, int'(exp_rdy));
         check("rnd_wr_en", rf_wr_en, int'(wbvv));
         check("rnd_rd_en", rf_rd_en, int'(ivv && exp_rdy));

         p_iv = ivv; p_wb = wbb; p_wbv = wbvv; p_or = orv; p_rdy = exp_rdy; p_ov = exp_ov;
         p_s0 = s0v; p_s1 = s1v; p_d = dv; p_wa = wav; p_wd = wdv;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
